// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction-memory write port, decode control and the IF/ID outputs.
interface instruction_fetch_if #(
  parameter int unsigned AW = 6
);
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          stall;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic [31:0]   pc;
  logic [31:0]   instr;
  logic [5:0]    opcode;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic [4:0]    rd;
  logic [15:0]   imm;
  logic          instr_valid;
  logic          halted;

  modport master (
    output imem_we, imem_addr, imem_wdata, stall, redirect, redirect_pc,
    input  pc, instr, opcode, rs, rt, rd, imm, instr_valid, halted
  );

  modport slave (
    input  imem_we, imem_addr, imem_wdata, stall, redirect, redirect_pc,
    output pc, instr, opcode, rs, rt, rd, imm, instr_valid, halted
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: local instruction memory, fetch PC, IF/ID register and halt detection.
module instruction_fetch #(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic               clk,
  input logic               rst_n,
  instruction_fetch_if.slave bus
);
  localparam int unsigned AW      = $clog2(IMEM_DEPTH);
  localparam logic [5:0]  HALT_OP = 6'h3F;

  typedef enum logic {RUN, HALT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic          valid_q, valid_d;
  logic [31:0]   mem [IMEM_DEPTH];
  logic [AW-1:0] rd_idx;
  logic          in_range;
  logic [31:0]   rd_word;

  // Read word selection; addresses past the end of memory read as zero.
  assign rd_idx   = fetch_pc_q[AW+1:2];
  assign in_range = (fetch_pc_q >> (AW + 2)) == 32'd0;
  assign rd_word  = in_range ? mem[rd_idx] : 32'h0000_0000;

  // Memory write port, active in every state; no reset on contents.
  always_ff @(posedge clk) begin
    if (bus.imem_we) mem[bus.imem_addr] <= bus.imem_wdata;
  end

  // State and pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      pc_q       <= 32'h0;
      instr_q    <= 32'h0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

  // Next-state logic: redirect beats stall, stall beats halt, otherwise fetch.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    case (state_q)
      RUN: begin
        if (bus.redirect) begin
          fetch_pc_d = bus.redirect_pc;
          pc_d       = 32'h0;
          instr_d    = 32'h0;
          valid_d    = 1'b0;
        end else if (bus.stall) begin
          // hold everything
        end else if (valid_q && (instr_q[31:26] == HALT_OP)) begin
          state_d = HALT;
          valid_d = 1'b0;
        end else begin
          instr_d    = rd_word;
          pc_d       = fetch_pc_q;
          valid_d    = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      HALT: begin
        // frozen until reset
      end
    endcase
  end

  // Outputs: the IF/ID register and its field slices.
  assign bus.pc          = pc_q;
  assign bus.instr       = instr_q;
  assign bus.opcode      = instr_q[31:26];
  assign bus.rs          = instr_q[25:21];
  assign bus.rt          = instr_q[20:16];
  assign bus.rd          = instr_q[15:11];
  assign bus.imm         = instr_q[15:0];
  assign bus.instr_valid = valid_q;
  assign bus.halted      = (state_q == HALT);
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch.
module tb_instruction_fetch;
  logic clk = 1'b0;
  logic rst_n;
  int   compared = 0;
  int   mismatched = 0;

  instruction_fetch_if #(.AW(6)) bus ();

  instruction_fetch #(.IMEM_DEPTH(64), .RESET_PC(32'h0000_0000)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic out(input string tag, input logic [31:0] epc, input logic [31:0] einstr,
                     input logic evalid, input logic ehalt);
    chk({tag, ".pc"}, bus.pc, epc);
    chk({tag, ".instr"}, bus.instr, einstr);
    chk({tag, ".valid"}, 32'(bus.instr_valid), 32'(evalid));
    chk({tag, ".halted"}, 32'(bus.halted), 32'(ehalt));
  endtask

  logic [31:0] init_words [8];

  initial begin
    init_words = '{32'h2001_0005, 32'h0022_1820, 32'h8C04_0000, 32'hAC04_0004,
                   32'h3C05_1234, 32'h2406_0055, 32'h0000_0000, 32'h0000_0000};
    rst_n = 1'b0;
    bus.imem_we = 1'b0; bus.imem_addr = '0; bus.imem_wdata = '0;
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;

    // Load memory while in reset
    for (int i = 0; i < 8; i++) begin
      bus.imem_we = 1'b1; bus.imem_addr = 6'(i); bus.imem_wdata = init_words[i];
      step();
    end
    bus.imem_we = 1'b0;
    out("reset", 32'h0, 32'h0, 1'b0, 1'b0);

    // Sequential fetch
    rst_n = 1'b1;
    step(); out("f0", 32'h0, 32'h2001_0005, 1'b1, 1'b0);
    chk("f0.opcode", 32'(bus.opcode), 32'h08);
    chk("f0.rt", 32'(bus.rt), 32'h01);
    chk("f0.imm", 32'(bus.imm), 32'h0005);
    step(); out("f4", 32'h4, 32'h0022_1820, 1'b1, 1'b0);
    chk("f4.opcode", 32'(bus.opcode), 32'h00);
    chk("f4.rs", 32'(bus.rs), 32'h01);
    chk("f4.rd", 32'(bus.rd), 32'h03);

    // Stall holds pc=4
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); out("stall", 32'h4, 32'h0022_1820, 1'b1, 1'b0);
    end
    bus.stall = 1'b0;
    step(); out("f8", 32'h8, 32'h8C04_0000, 1'b1, 1'b0);
    chk("f8.opcode", 32'(bus.opcode), 32'h23);
    step(); out("f12", 32'hC, 32'hAC04_0004, 1'b1, 1'b0);
    chk("f12.opcode", 32'(bus.opcode), 32'h2B);

    // Redirect beats stall
    bus.redirect = 1'b1; bus.redirect_pc = 32'h10; bus.stall = 1'b1;
    step(); out("redir_bubble", 32'h0, 32'h0, 1'b0, 1'b0);
    bus.redirect = 1'b0; bus.stall = 1'b0;
    step(); out("redir_tgt", 32'h10, 32'h3C05_1234, 1'b1, 1'b0);

    // Write to the word being fetched returns old data; refetch sees new
    bus.imem_we = 1'b1; bus.imem_addr = 6'd5; bus.imem_wdata = 32'hDEAD_BEEF;
    step(); out("wr_old", 32'h14, 32'h2406_0055, 1'b1, 1'b0);
    bus.imem_we = 1'b0;
    bus.redirect = 1'b1; bus.redirect_pc = 32'h14;
    step(); out("wr_bubble", 32'h0, 32'h0, 1'b0, 1'b0);
    bus.redirect = 1'b0;
    step(); out("wr_new", 32'h14, 32'hDEAD_BEEF, 1'b1, 1'b0);

    // Out of range and PC wrap
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0400;
    step(); bus.redirect = 1'b0;
    step(); out("oor", 32'h400, 32'h0, 1'b1, 1'b0);
    bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
    step(); bus.redirect = 1'b0;
    step(); out("top", 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0);
    step(); out("wrap", 32'h0, 32'h2001_0005, 1'b1, 1'b0);

    // Halt: plant halt opcode in word 2 while fetching word 1
    bus.imem_we = 1'b1; bus.imem_addr = 6'd2; bus.imem_wdata = 32'hFC00_0000;
    step(); out("h4", 32'h4, 32'h0022_1820, 1'b1, 1'b0);
    bus.imem_we = 1'b0;
    step(); out("h8", 32'h8, 32'hFC00_0000, 1'b1, 1'b0);
    chk("h8.opcode", 32'(bus.opcode), 32'h3F);
    step(); out("halt", 32'h8, 32'hFC00_0000, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      bus.redirect = i[0]; bus.redirect_pc = 32'h20; bus.stall = i[1];
      step(); out("frozen", 32'h8, 32'hFC00_0000, 1'b0, 1'b1);
    end
    bus.redirect = 1'b0; bus.stall = 1'b0;

    // Asynchronous reset exits HALT immediately
    rst_n = 1'b0;
    #2; out("async_rst", 32'h0, 32'h0, 1'b0, 1'b0);
    #2; rst_n = 1'b1;
    step(); out("re0", 32'h0, 32'h2001_0005, 1'b1, 1'b0);
    step(); out("re4", 32'h4, 32'h0022_1820, 1'b1, 1'b0);

    // Redirect on the edge the halt word would be fetched discards it
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0;
    step(); out("halt_disc", 32'h0, 32'h0, 1'b0, 1'b0);
    bus.redirect = 1'b0;
    step(); out("rf0", 32'h0, 32'h2001_0005, 1'b1, 1'b0);
    step(); out("rf4", 32'h4, 32'h0022_1820, 1'b1, 1'b0);
    step(); out("rf8", 32'h8, 32'hFC00_0000, 1'b1, 1'b0);

    // Halt word under stall stays presented, halts on first unstalled edge
    bus.stall = 1'b1;
    step(); out("hstall1", 32'h8, 32'hFC00_0000, 1'b1, 1'b0);
    step(); out("hstall2", 32'h8, 32'hFC00_0000, 1'b1, 1'b0);
    bus.stall = 1'b0;
    step(); out("halt2", 32'h8, 32'hFC00_0000, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
